// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared types for the memory arbiter slice: the controller state encoding,
// the owner encoding used for round-robin fairness and response routing, and
// the default port widths.
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 64;
    localparam int DEFAULT_DATA_WIDTH = 64;

    // Bit positions inside the one-hot grant vector produced by arb_rr2.
    localparam int GRANT_IFU = 0;
    localparam int GRANT_LSU = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arbState_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arbiter_arb_rr2.sv
// -----------------------------------------------------------------------------
// arb_rr2
// Two-way round-robin picker between the instruction-fetch and load/store
// requesters. Purely combinational; the caller owns the last-grant register.
//
// Ports:
//   ifu_valid_i   - IFU request pending
//   lsu_valid_i   - LSU request pending
//   last_grant_i  - requester that won the previous arbitration
//   grant_o       - one-hot grant, bit GRANT_IFU / GRANT_LSU, zero if no request
// -----------------------------------------------------------------------------
module arb_rr2
    import mem_arbiter_pkg::*;
(
    input  logic       ifu_valid_i,
    input  logic       lsu_valid_i,
    input  owner_e     last_grant_i,
    output logic [1:0] grant_o
);

    // On a tie the requester that did not win last time gets the slot, so
    // neither side can starve the other; a lone request always wins.
    always_comb begin
        grant_o = '0;
        if (ifu_valid_i && lsu_valid_i) begin
            if (last_grant_i == OWN_IFU) begin
                grant_o[GRANT_LSU] = 1'b1;
            end else begin
                grant_o[GRANT_IFU] = 1'b1;
            end
        end else if (ifu_valid_i) begin
            grant_o[GRANT_IFU] = 1'b1;
        end else if (lsu_valid_i) begin
            grant_o[GRANT_LSU] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one memory port between an instruction-fetch unit (read only) and a
// load/store unit. Exactly one transaction is in flight at a time:
// IDLE accepts and latches a request, ISSUE presents it to memory until the
// memory accepts it, WAIT forwards the memory response to the owner.
//
// Ports:
//   clk_i, rst_i                  - clock, asynchronous active-high reset
//   ifu_req_valid_i/_ready_o      - IFU request handshake, ifu_addr_i address
//   ifu_resp_valid_o              - one-cycle pulse, fetch data on resp_rdata_o
//   lsu_req_valid_i/_ready_o      - LSU request handshake
//   lsu_addr_i/_wen_i/_wdata_i/_wmask_i - LSU request fields
//   lsu_resp_valid_o              - one-cycle pulse, load data / store ack
//   resp_rdata_o                  - shared response data, zero when idle
//   mem_req_valid_o/mem_req_ready_i - memory request handshake
//   mem_addr_o/_wen_o/_wdata_o/_wmask_o - latched request fields
//   mem_resp_valid_i/mem_rdata_i  - memory response
//   busy_o                        - controller not in IDLE
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    ifu_req_valid_i,
    output logic                    ifu_req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   ifu_addr_i,
    output logic                    ifu_resp_valid_o,

    input  logic                    lsu_req_valid_i,
    output logic                    lsu_req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   lsu_addr_i,
    input  logic                    lsu_wen_i,
    input  logic [DATA_WIDTH-1:0]   lsu_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] lsu_wmask_i,
    output logic                    lsu_resp_valid_o,

    output logic [DATA_WIDTH-1:0]   resp_rdata_o,

    output logic                    mem_req_valid_o,
    input  logic                    mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic                    mem_wen_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0] mem_wmask_o,
    input  logic                    mem_resp_valid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,

    output logic                    busy_o
);

    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    arbState_e               state_q, state_d;
    owner_e                  lastGrant_q, lastGrant_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    wen_q, wen_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [MASK_WIDTH-1:0]   wmask_q, wmask_d;

    logic [1:0]              grant;
    logic                    acceptIfu;
    logic                    acceptLsu;
    logic                    respFire;

    arb_rr2 u_arb_rr2 (
        .ifu_valid_i  (ifu_req_valid_i),
        .lsu_valid_i  (lsu_req_valid_i),
        .last_grant_i (lastGrant_q),
        .grant_o      (grant)
    );

    // A grant only becomes an accept in IDLE. Reset is folded in so that no
    // ready is advertised while the controller is being held in reset.
    assign acceptIfu = (state_q == IDLE) && grant[GRANT_IFU] && !rst_i;
    assign acceptLsu = (state_q == IDLE) && grant[GRANT_LSU] && !rst_i;

    // lastGrant_q doubles as the owner of the in-flight transaction: it is
    // written only at accept, so during ISSUE/WAIT it names the requester
    // whose response we are waiting for.
    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        addr_d      = addr_q;
        wen_d       = wen_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        unique case (state_q)
            IDLE: begin
                if (acceptIfu) begin
                    state_d     = ISSUE;
                    lastGrant_d = OWN_IFU;
                    addr_d      = ifu_addr_i;
                    wen_d       = 1'b0;
                    wdata_d     = '0;
                    wmask_d     = '0;
                end else if (acceptLsu) begin
                    state_d     = ISSUE;
                    lastGrant_d = OWN_LSU;
                    addr_d      = lsu_addr_i;
                    wen_d       = lsu_wen_i;
                    wdata_d     = lsu_wdata_i;
                    wmask_d     = lsu_wmask_i;
                end
            end
            ISSUE: begin
                if (mem_req_ready_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller state and latched request fields. Reset abandons any
    // in-flight transaction; the first tie afterwards goes to the LSU.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            lastGrant_q <= OWN_IFU;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= '0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
        end
    end

    // The response is forwarded in the same cycle memory presents it, which
    // keeps accept-to-response at two cycles when memory is immediate.
    assign respFire = (state_q == WAIT) && mem_resp_valid_i;

    assign ifu_req_ready_o  = acceptIfu;
    assign lsu_req_ready_o  = acceptLsu;
    assign ifu_resp_valid_o = respFire && (lastGrant_q == OWN_IFU);
    assign lsu_resp_valid_o = respFire && (lastGrant_q == OWN_LSU);
    assign resp_rdata_o     = respFire ? mem_rdata_i : '0;

    assign mem_req_valid_o  = (state_q == ISSUE);
    assign mem_addr_o       = addr_q;
    assign mem_wen_o        = wen_q;
    assign mem_wdata_o      = wdata_q;
    assign mem_wmask_o      = wmask_q;

    assign busy_o           = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter: single-requester transactions from a vector
// table with varying memory stall patterns, plus hand-written sequences for
// round-robin ties, stray memory responses, reset in WAIT and requester
// fields changing after accept.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int MW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          ifuReqValid;
    logic          ifuReqReady;
    logic [AW-1:0] ifuAddr;
    logic          ifuRespValid;
    logic          lsuReqValid;
    logic          lsuReqReady;
    logic [AW-1:0] lsuAddr;
    logic          lsuWen;
    logic [DW-1:0] lsuWdata;
    logic [MW-1:0] lsuWmask;
    logic          lsuRespValid;
    logic [DW-1:0] respRdata;
    logic          memReqValid;
    logic          memReqReady;
    logic [AW-1:0] memAddr;
    logic          memWen;
    logic [DW-1:0] memWdata;
    logic [MW-1:0] memWmask;
    logic          memRespValid;
    logic [DW-1:0] memRdata;
    logic          busy;

    int checkCount = 0;
    int failCount  = 0;

    typedef struct {
        bit            isLsu;
        logic [AW-1:0] addr;
        logic          wen;
        logic [DW-1:0] wdata;
        logic [MW-1:0] wmask;
        int            readyDelay;
        int            respDelay;
        logic [DW-1:0] memData;
        logic [AW-1:0] expAddr;
        logic          expWen;
        logic [DW-1:0] expWdata;
        logic [MW-1:0] expWmask;
        logic          expIfuResp;
        logic          expLsuResp;
        logic [DW-1:0] expRdata;
    } vector_t;

    vector_t vectors[5];

    mem_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .ifu_req_valid_i  (ifuReqValid),
        .ifu_req_ready_o  (ifuReqReady),
        .ifu_addr_i       (ifuAddr),
        .ifu_resp_valid_o (ifuRespValid),
        .lsu_req_valid_i  (lsuReqValid),
        .lsu_req_ready_o  (lsuReqReady),
        .lsu_addr_i       (lsuAddr),
        .lsu_wen_i        (lsuWen),
        .lsu_wdata_i      (lsuWdata),
        .lsu_wmask_i      (lsuWmask),
        .lsu_resp_valid_o (lsuRespValid),
        .resp_rdata_o     (respRdata),
        .mem_req_valid_o  (memReqValid),
        .mem_req_ready_i  (memReqReady),
        .mem_addr_o       (memAddr),
        .mem_wen_o        (memWen),
        .mem_wdata_o      (memWdata),
        .mem_wmask_o      (memWmask),
        .mem_resp_valid_i (memRespValid),
        .mem_rdata_i      (memRdata),
        .busy_o           (busy)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Compare one observed value against its expected value and tally it.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    // Step to just after the next rising edge, where inputs are driven.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Finish a transaction that has just entered ISSUE: memory accepts at
    // once and answers with 0x77 in the first WAIT cycle.
    task automatic completeTransaction(input bit expLsu, input logic [63:0] expAddr,
                                       input string tag);
        memReqReady = 1'b1;
        @(negedge clk);
        checkOutput({tag, ".memReqValid"}, memReqValid, 1);
        checkOutput({tag, ".memAddr"}, memAddr, expAddr);
        checkOutput({tag, ".ifuReadyIssue"}, ifuReqReady, 0);
        checkOutput({tag, ".lsuReadyIssue"}, lsuReqReady, 0);
        nextCycle();
        memReqReady  = 1'b0;
        memRespValid = 1'b1;
        memRdata     = 64'h77;
        @(negedge clk);
        checkOutput({tag, ".ifuResp"}, ifuRespValid, !expLsu);
        checkOutput({tag, ".lsuResp"}, lsuRespValid, expLsu);
        checkOutput({tag, ".respRdata"}, respRdata, 64'h77);
        nextCycle();
        memRespValid = 1'b0;
        memRdata     = '0;
    endtask

    // Run one table vector as a full transaction starting from IDLE.
    task automatic applyStimulus(input int idx);
        vector_t v;
        string   tag;
        v   = vectors[idx];
        tag = $sformatf("vec%0d", idx);
        lsuWen   = v.wen;
        lsuWdata = v.wdata;
        lsuWmask = v.wmask;
        if (v.isLsu) begin
            lsuReqValid = 1'b1;
            lsuAddr     = v.addr;
            ifuAddr     = 64'hBAD0;
        end else begin
            ifuReqValid = 1'b1;
            ifuAddr     = v.addr;
            lsuAddr     = 64'hBAD1;
        end
        @(negedge clk);
        checkOutput({tag, ".ifuReady"}, ifuReqReady, !v.isLsu);
        checkOutput({tag, ".lsuReady"}, lsuReqReady, v.isLsu);
        checkOutput({tag, ".memReqValidAccept"}, memReqValid, 0);
        nextCycle();
        // Scramble the requester side; the latched fields must not follow.
        ifuReqValid = 1'b0;
        lsuReqValid = 1'b0;
        ifuAddr     = '1;
        lsuAddr     = '1;
        lsuWdata    = '1;
        lsuWmask    = '1;
        lsuWen      = ~v.wen;
        for (int k = 0; k <= v.readyDelay; k++) begin
            memReqReady = (k == v.readyDelay);
            @(negedge clk);
            checkOutput($sformatf("%s.issue%0d.memReqValid", tag, k), memReqValid, 1);
            checkOutput($sformatf("%s.issue%0d.memAddr", tag, k), memAddr, v.expAddr);
            checkOutput($sformatf("%s.issue%0d.memWen", tag, k), memWen, v.expWen);
            checkOutput($sformatf("%s.issue%0d.memWmask", tag, k), memWmask, v.expWmask);
            if (v.isLsu) begin
                checkOutput($sformatf("%s.issue%0d.memWdata", tag, k), memWdata, v.expWdata);
            end
            checkOutput($sformatf("%s.issue%0d.busy", tag, k), busy, 1);
            checkOutput($sformatf("%s.issue%0d.ifuResp", tag, k), ifuRespValid, 0);
            checkOutput($sformatf("%s.issue%0d.lsuResp", tag, k), lsuRespValid, 0);
            nextCycle();
        end
        memReqReady = 1'b0;
        for (int k = 0; k <= v.respDelay; k++) begin
            memRespValid = (k == v.respDelay);
            memRdata     = (k == v.respDelay) ? v.memData : (64'hFEED_FACE_0000_0000 | 64'(k));
            @(negedge clk);
            checkOutput($sformatf("%s.wait%0d.memReqValid", tag, k), memReqValid, 0);
            checkOutput($sformatf("%s.wait%0d.ifuResp", tag, k), ifuRespValid,
                        (k == v.respDelay) ? v.expIfuResp : 1'b0);
            checkOutput($sformatf("%s.wait%0d.lsuResp", tag, k), lsuRespValid,
                        (k == v.respDelay) ? v.expLsuResp : 1'b0);
            checkOutput($sformatf("%s.wait%0d.respRdata", tag, k), respRdata,
                        (k == v.respDelay) ? v.expRdata : 64'h0);
            nextCycle();
        end
        memRespValid = 1'b0;
        memRdata     = '0;
        @(negedge clk);
        checkOutput({tag, ".idleBusy"}, busy, 0);
        checkOutput({tag, ".idleIfuResp"}, ifuRespValid, 0);
        checkOutput({tag, ".idleLsuResp"}, lsuRespValid, 0);
        nextCycle();
    endtask

    initial begin
        // IFU read of 0x8000_0000, immediate memory: response at accept+2.
        vectors[0] = '{isLsu: 1'b0, addr: 64'h8000_0000, wen: 1'b1, wdata: 64'h1111,
                       wmask: 8'hFF, readyDelay: 0, respDelay: 0, memData: 64'h13,
                       expAddr: 64'h8000_0000, expWen: 1'b0, expWdata: 64'h0,
                       expWmask: 8'h00, expIfuResp: 1'b1, expLsuResp: 1'b0,
                       expRdata: 64'h13};
        // LSU store, memory stalls three cycles: fields held for four.
        vectors[1] = '{isLsu: 1'b1, addr: 64'h100, wen: 1'b1, wdata: 64'hDEAD_BEEF,
                       wmask: 8'h0F, readyDelay: 3, respDelay: 0, memData: 64'h0,
                       expAddr: 64'h100, expWen: 1'b1, expWdata: 64'hDEAD_BEEF,
                       expWmask: 8'h0F, expIfuResp: 1'b0, expLsuResp: 1'b1,
                       expRdata: 64'h0};
        // LSU load with both a request stall and a slow response.
        vectors[2] = '{isLsu: 1'b1, addr: 64'h2000, wen: 1'b0, wdata: 64'h0,
                       wmask: 8'hFF, readyDelay: 1, respDelay: 2,
                       memData: 64'h0123_4567_89AB_CDEF,
                       expAddr: 64'h2000, expWen: 1'b0, expWdata: 64'h0,
                       expWmask: 8'hFF, expIfuResp: 1'b0, expLsuResp: 1'b1,
                       expRdata: 64'h0123_4567_89AB_CDEF};
        // IFU read with a slow response and all-ones data.
        vectors[3] = '{isLsu: 1'b0, addr: 64'h8000_0004, wen: 1'b1, wdata: 64'h2222,
                       wmask: 8'h33, readyDelay: 0, respDelay: 1,
                       memData: 64'hFFFF_FFFF_FFFF_FFFF,
                       expAddr: 64'h8000_0004, expWen: 1'b0, expWdata: 64'h0,
                       expWmask: 8'h00, expIfuResp: 1'b1, expLsuResp: 1'b0,
                       expRdata: 64'hFFFF_FFFF_FFFF_FFFF};
        // LSU store at the top of the address space, single high byte.
        vectors[4] = '{isLsu: 1'b1, addr: 64'hFFFF_FFFF_FFFF_FFF8, wen: 1'b1,
                       wdata: 64'hA5A5_5A5A_0F0F_F0F0, wmask: 8'h80, readyDelay: 2,
                       respDelay: 1, memData: 64'h99,
                       expAddr: 64'hFFFF_FFFF_FFFF_FFF8, expWen: 1'b1,
                       expWdata: 64'hA5A5_5A5A_0F0F_F0F0, expWmask: 8'h80,
                       expIfuResp: 1'b0, expLsuResp: 1'b1, expRdata: 64'h99};

        rst          = 1'b1;
        ifuReqValid  = 1'b1;
        ifuAddr      = 64'h1234;
        lsuReqValid  = 1'b1;
        lsuAddr      = 64'h5678;
        lsuWen       = 1'b1;
        lsuWdata     = 64'h9999;
        lsuWmask     = 8'hFF;
        memReqReady  = 1'b0;
        memRespValid = 1'b0;
        memRdata     = '0;

        // Reset state, with requests pending so ready gating is visible.
        #2;
        checkOutput("reset.ifuReady", ifuReqReady, 0);
        checkOutput("reset.lsuReady", lsuReqReady, 0);
        checkOutput("reset.memReqValid", memReqValid, 0);
        checkOutput("reset.busy", busy, 0);
        checkOutput("reset.memAddr", memAddr, 0);
        checkOutput("reset.memWen", memWen, 0);
        checkOutput("reset.memWdata", memWdata, 0);
        checkOutput("reset.memWmask", memWmask, 0);
        checkOutput("reset.ifuResp", ifuRespValid, 0);
        checkOutput("reset.lsuResp", lsuRespValid, 0);
        checkOutput("reset.respRdata", respRdata, 0);
        ifuReqValid = 1'b0;
        lsuReqValid = 1'b0;
        nextCycle();
        rst = 1'b0;
        nextCycle();

        // Round-robin: first tie to LSU, held IFU next, third tie to LSU.
        ifuReqValid = 1'b1;
        ifuAddr     = 64'h1000;
        lsuReqValid = 1'b1;
        lsuAddr     = 64'h2000;
        lsuWen      = 1'b0;
        lsuWmask    = 8'hFF;
        @(negedge clk);
        checkOutput("tie1.lsuReady", lsuReqReady, 1);
        checkOutput("tie1.ifuReady", ifuReqReady, 0);
        nextCycle();
        lsuReqValid = 1'b0;
        completeTransaction(1'b1, 64'h2000, "tie1");
        @(negedge clk);
        checkOutput("tie2.ifuReady", ifuReqReady, 1);
        checkOutput("tie2.lsuReady", lsuReqReady, 0);
        nextCycle();
        ifuReqValid = 1'b0;
        completeTransaction(1'b0, 64'h1000, "tie2");
        ifuReqValid = 1'b1;
        ifuAddr     = 64'h1004;
        lsuReqValid = 1'b1;
        lsuAddr     = 64'h2008;
        @(negedge clk);
        checkOutput("tie3.lsuReady", lsuReqReady, 1);
        checkOutput("tie3.ifuReady", ifuReqReady, 0);
        nextCycle();
        lsuReqValid = 1'b0;
        completeTransaction(1'b1, 64'h2008, "tie3");
        @(negedge clk);
        checkOutput("tie4.ifuReady", ifuReqReady, 1);
        nextCycle();
        ifuReqValid = 1'b0;
        completeTransaction(1'b0, 64'h1004, "tie4");

        for (int i = 0; i < 5; i++) begin
            applyStimulus(i);
        end

        // Stray memory response while IDLE.
        memRespValid = 1'b1;
        memRdata     = 64'hABCD;
        @(negedge clk);
        checkOutput("strayIdle.ifuResp", ifuRespValid, 0);
        checkOutput("strayIdle.lsuResp", lsuRespValid, 0);
        checkOutput("strayIdle.respRdata", respRdata, 0);
        checkOutput("strayIdle.busy", busy, 0);
        nextCycle();
        memRespValid = 1'b0;
        @(negedge clk);
        checkOutput("strayIdle.busyAfter", busy, 0);

        // Stray memory response while ISSUE with memory not ready.
        nextCycle();
        ifuReqValid = 1'b1;
        ifuAddr     = 64'h3000;
        @(negedge clk);
        checkOutput("strayIssue.ifuReady", ifuReqReady, 1);
        nextCycle();
        ifuReqValid  = 1'b0;
        memRespValid = 1'b1;
        @(negedge clk);
        checkOutput("strayIssue.memReqValid", memReqValid, 1);
        checkOutput("strayIssue.ifuResp", ifuRespValid, 0);
        checkOutput("strayIssue.respRdata", respRdata, 0);
        nextCycle();
        memRespValid = 1'b0;
        @(negedge clk);
        checkOutput("strayIssue.stillIssue", memReqValid, 1);
        nextCycle();
        completeTransaction(1'b0, 64'h3000, "strayIssue");

        // Reset asserted while WAIT: everything drops at once, no pulse.
        ifuReqValid = 1'b1;
        ifuAddr     = 64'h4400;
        @(negedge clk);
        checkOutput("rstWait.ifuReady", ifuReqReady, 1);
        nextCycle();
        ifuReqValid = 1'b0;
        memReqReady = 1'b1;
        nextCycle();
        memReqReady  = 1'b0;
        rst          = 1'b1;
        memRespValid = 1'b1;
        memRdata     = 64'h55;
        #1;
        checkOutput("rstWait.busy", busy, 0);
        checkOutput("rstWait.ifuResp", ifuRespValid, 0);
        checkOutput("rstWait.respRdata", respRdata, 0);
        checkOutput("rstWait.memReqValid", memReqValid, 0);
        checkOutput("rstWait.memAddr", memAddr, 0);
        @(negedge clk);
        checkOutput("rstWait.ifuRespLater", ifuRespValid, 0);
        nextCycle();
        rst          = 1'b0;
        memRespValid = 1'b0;
        memRdata     = '0;
        ifuReqValid  = 1'b1;
        ifuAddr      = 64'h4800;
        @(negedge clk);
        checkOutput("postReset.ifuReady", ifuReqReady, 1);
        nextCycle();
        ifuReqValid = 1'b0;
        completeTransaction(1'b0, 64'h4800, "postReset");

        // IFU changes its address during WAIT; the latched one must persist.
        ifuReqValid = 1'b1;
        ifuAddr     = 64'h4000;
        @(negedge clk);
        checkOutput("addrHold.ifuReady", ifuReqReady, 1);
        nextCycle();
        ifuReqValid = 1'b0;
        memReqReady = 1'b1;
        nextCycle();
        memReqReady = 1'b0;
        ifuReqValid = 1'b1;
        ifuAddr     = 64'h5000;
        @(negedge clk);
        checkOutput("addrHold.memAddr", memAddr, 64'h4000);
        checkOutput("addrHold.ifuReadyWait", ifuReqReady, 0);
        checkOutput("addrHold.busy", busy, 1);
        nextCycle();
        memRespValid = 1'b1;
        memRdata     = 64'h66;
        @(negedge clk);
        checkOutput("addrHold.ifuResp", ifuRespValid, 1);
        checkOutput("addrHold.respRdata", respRdata, 64'h66);
        nextCycle();
        memRespValid = 1'b0;
        memRdata     = '0;
        @(negedge clk);
        checkOutput("addrHold.nextReady", ifuReqReady, 1);
        nextCycle();
        ifuReqValid = 1'b0;
        completeTransaction(1'b0, 64'h5000, "addrHoldNext");

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_WIDTH, default 64, width of all address ports.
REQ-002 Parameter: DATA_WIDTH, default 64, width of all data ports; byte mask width is DATA_WIDTH/8.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 ifu_req_valid  input  1  instruction-fetch read request.
REQ-006 ifu_req_ready  output  1  arbiter accepts IFU request this cycle.
REQ-007 ifu_addr  input  ADDR_WIDTH  fetch address.
REQ-008 ifu_resp_valid  output  1  one-cycle pulse: fetch data valid on resp_rdata.
REQ-009 lsu_req_valid  input  1  load/store request.
REQ-010 lsu_req_ready  output  1  arbiter accepts LSU request this cycle.
REQ-011 lsu_addr / lsu_wen / lsu_wdata / lsu_wmask  input  ADDR_WIDTH / 1 / DATA_WIDTH / DATA_WIDTH/8  LSU address, write enable, write data, byte mask.
REQ-012 lsu_resp_valid  output  1  one-cycle pulse: load data or store acknowledge.
REQ-013 resp_rdata  output  DATA_WIDTH  response data, shared by both requesters.
REQ-014 mem_req_valid / mem_req_ready  output / input  1 / 1  memory-port request handshake.
REQ-015 mem_addr / mem_wen / mem_wdata / mem_wmask  output  ADDR_WIDTH / 1 / DATA_WIDTH / DATA_WIDTH/8  latched request fields.
REQ-016 mem_resp_valid / mem_rdata  input  1 / DATA_WIDTH  memory response for reads and writes.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT; exactly one transaction outstanding.
REQ-019 IDLE: grant at most one requester; the granted requester's ready is asserted combinationally in the same cycle and its fields are latched; next state ISSUE.
REQ-020 Tie, with both valid in IDLE: grant the requester not granted last (last_grant register); a single valid request is granted regardless of last_grant.
REQ-021 IFU transactions set mem_wen=0 and mem_wmask=0; mem_wdata is don't-care.
REQ-022 ISSUE: mem_req_valid=1 with latched fields held stable; on mem_req_ready go to WAIT; otherwise stay.
REQ-023 WAIT: on mem_resp_valid, pulse the owner's resp_valid for exactly one cycle with resp_rdata=mem_rdata, then go to IDLE.
REQ-024 Minimum latency: accept at cycle N, mem_req_valid at N+1, resp_valid at N+2 when ready and response are immediate.
REQ-025 No new request is accepted in ISSUE or WAIT; both readys stay 0; back-to-back accepts are separated by at least one IDLE cycle.
REQ-026 mem_resp_valid outside WAIT is ignored: no state change and no resp pulse.
REQ-027 Requesters hold valid and fields until ready; the arbiter latches fields only at accept and does not re-sample them.
REQ-028 resp_rdata is 0 when no resp_valid is asserted.

Reset
REQ-029 Reset asynchronously forces state=IDLE and last_grant=IFU, so LSU wins the first tie; all readys, resp_valids and mem_req_valid are 0; latched fields are 0.
REQ-030 Reset mid-transaction drops the transaction: no resp pulse at or after reset, and the first request after reset release is handled normally.

Structure
REQ-031 Shared package holds the FSM state enum (IDLE/ISSUE/WAIT) and the owner enum (OWN_IFU/OWN_LSU); widths come from the existing global defines header.
REQ-032 One sub-module, arb_rr2, implements the two-way round-robin pick (inputs: two valids and last_grant; output: one-hot grant); the FSM and latches stay in mem_arbiter.

Verification
REQ-033 IFU-only read of 0x8000_0000, with mem_req_ready=1 and a response of 0x13 in WAIT -> ifu_resp_valid at accept+2 with resp_rdata=0x13; lsu_resp_valid never asserted.
REQ-034 Both valid in the first IDLE after reset -> LSU granted first; IFU granted on the next IDLE; a third simultaneous pair -> LSU granted.
REQ-035 LSU store to 0x100 with wdata 0xDEAD_BEEF and wmask 0x0F, with mem_req_ready held low 3 cycles -> mem fields stable for 4 cycles, then lsu_resp_valid pulses once.
REQ-036 Stray mem_resp_valid during IDLE or ISSUE -> no resp pulse and no state change.
REQ-037 rst asserted during WAIT -> outputs 0 immediately, no resp pulse; a later IFU request completes normally.
REQ-038 IFU request changes its address while in WAIT -> mem_addr keeps the originally latched value.
